// File: rtl/alu_if.sv
// ALU stimulus interface: the driver side issues operands/commands, the ALU side returns registered results.
interface alu_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CMD_WIDTH = 4
);
  logic                 ce;
  logic                 mode;
  logic [CMD_WIDTH-1:0] cmd;
  logic [1:0]           inp_valid;
  logic [WIDTH-1:0]     opa;
  logic [WIDTH-1:0]     opb;
  logic                 cin;
  logic [WIDTH:0]       res;
  logic                 cout;
  logic                 oflow;
  logic                 g;
  logic                 l;
  logic                 e;
  logic                 err;

  modport master (
    output ce, mode, cmd, inp_valid, opa, opb, cin,
    input  res, cout, oflow, g, l, e, err
  );

  modport slave (
    input  ce, mode, cmd, inp_valid, opa, opb, cin,
    output res, cout, oflow, g, l, e, err
  );
endinterface

// File: rtl/alu_rtl.sv
// ALU responder: gathers split operands under a small FSM and returns registered results/flags.
// Optional macro ALU_OUT_PIPE_EN adds one ce-gated output register stage (latency 2).
module alu_rtl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CMD_WIDTH = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  alu_bus
);
  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_A, S_WAIT_B} state_t;

  typedef struct packed {
    logic [WIDTH:0] res;
    logic           cout;
    logic           oflow;
    logic           g;
    logic           l;
    logic           e;
    logic           err;
  } result_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [WIDTH-1:0]     r_opa, r_opb;
  logic [CMD_WIDTH-1:0] r_cmd;
  logic                 r_mode, r_cin;
  logic                 w_lat_a, w_lat_b;
  result_t              r_out, w_out_nxt, w_out_q;
  logic                 w_out_ld;
  logic [1:0]           w_iv, w_need;
  logic                 w_legal, w_timeout;

  function automatic logic f_legal(input logic mode, input logic [CMD_WIDTH-1:0] cmd);
    return mode ? (int'(cmd) <= 8) : (int'(cmd) <= 13);
  endfunction

  // Operand requirement as {need_b, need_a}, aligned with inp_valid.
  function automatic logic [1:0] f_need(input logic mode, input logic [CMD_WIDTH-1:0] cmd);
    logic [1:0] n;
    n = 2'b11;
    if (mode) begin
      case (int'(cmd))
        4, 5:    n = 2'b01;
        6, 7:    n = 2'b10;
        default: n = 2'b11;
      endcase
    end else begin
      case (int'(cmd))
        6, 8, 9:   n = 2'b01;
        7, 10, 11: n = 2'b10;
        default:   n = 2'b11;
      endcase
    end
    return n;
  endfunction

  function automatic result_t f_compute(input logic mode, input logic [CMD_WIDTH-1:0] cmd,
                                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                        input logic cin);
    result_t            r;
    logic [WIDTH:0]     ea, eb, ec;
    logic [WIDTH-1:0]   lg;
    logic [2*WIDTH-1:0] rot;
    logic [SH_W-1:0]    sh;
    r   = '0;
    ea  = {1'b0, a};
    eb  = {1'b0, b};
    ec  = (WIDTH+1)'(cin);
    lg  = '0;
    rot = '0;
    sh  = b[SH_W-1:0];
    if (mode) begin
      case (int'(cmd))
        0: begin r.res = ea + eb;      r.cout  = r.res[WIDTH]; end
        1: begin r.res = ea - eb;      r.oflow = (ea < eb);    end
        2: begin r.res = ea + eb + ec; r.cout  = r.res[WIDTH]; end
        3: begin r.res = ea - eb - ec; r.oflow = (ea < (eb + ec)); end
        4: r.res = ea + (WIDTH+1)'(1);
        5: r.res = ea - (WIDTH+1)'(1);
        6: r.res = eb + (WIDTH+1)'(1);
        7: r.res = eb - (WIDTH+1)'(1);
        8: begin r.g = (a > b); r.l = (a < b); r.e = (a == b); end
        default: r.err = 1'b1;
      endcase
    end else begin
      case (int'(cmd))
        0:  lg = a & b;
        1:  lg = ~(a & b);
        2:  lg = a | b;
        3:  lg = ~(a | b);
        4:  lg = a ^ b;
        5:  lg = ~(a ^ b);
        6:  lg = ~a;
        7:  lg = ~b;
        8:  lg = a >> 1;
        9:  lg = a << 1;
        10: lg = b >> 1;
        11: lg = b << 1;
        12: begin rot = {a, a} << sh; lg = rot[2*WIDTH-1:WIDTH]; end
        13: begin rot = {a, a} >> sh; lg = rot[WIDTH-1:0];       end
        default: r.err = 1'b1;
      endcase
      // Rotate amounts beyond the operand width are rejected outright.
      if ((int'(cmd) == 12 || int'(cmd) == 13) && ((b >> SH_W) != '0)) begin
        r.err = 1'b1;
        lg    = '0;
      end
      r.res = {1'b0, lg};
    end
    return r;
  endfunction

  assign w_iv      = alu_bus.inp_valid;
  assign w_need    = f_need(alu_bus.mode, alu_bus.cmd);
  assign w_legal   = f_legal(alu_bus.mode, alu_bus.cmd);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (alu_bus.ce) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lat_a     = 1'b0;
    w_lat_b     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_legal && (w_need == 2'b11)) begin
          if (w_iv == 2'b01) begin
            w_state_nxt = S_WAIT_B;
            w_lat_a     = 1'b1;
          end else if (w_iv == 2'b10) begin
            w_state_nxt = S_WAIT_A;
            w_lat_b     = 1'b1;
          end
        end
      end
      S_WAIT_A: begin
        if (w_iv[0] || w_timeout) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_WAIT_B: begin
        if (w_iv[1] || w_timeout) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // While waiting, the latched command applies and any freshly presented operand wins.
  always_comb begin
    w_out_ld  = 1'b0;
    w_out_nxt = '0;
    case (r_state)
      S_IDLE: begin
        if (w_iv != 2'b00) begin
          if (!w_legal) begin
            w_out_ld      = 1'b1;
            w_out_nxt.err = 1'b1;
          end else if ((w_iv & w_need) == w_need) begin
            w_out_ld  = 1'b1;
            w_out_nxt = f_compute(alu_bus.mode, alu_bus.cmd, alu_bus.opa, alu_bus.opb, alu_bus.cin);
          end else if (w_need != 2'b11) begin
            w_out_ld      = 1'b1;
            w_out_nxt.err = 1'b1;
          end
        end
      end
      S_WAIT_A: begin
        if (w_iv[0]) begin
          w_out_ld  = 1'b1;
          w_out_nxt = f_compute(r_mode, r_cmd, alu_bus.opa, w_iv[1] ? alu_bus.opb : r_opb, r_cin);
        end else if (w_timeout) begin
          w_out_ld      = 1'b1;
          w_out_nxt.err = 1'b1;
        end
      end
      S_WAIT_B: begin
        if (w_iv[1]) begin
          w_out_ld  = 1'b1;
          w_out_nxt = f_compute(r_mode, r_cmd, w_iv[0] ? alu_bus.opa : r_opa, alu_bus.opb, r_cin);
        end else if (w_timeout) begin
          w_out_ld      = 1'b1;
          w_out_nxt.err = 1'b1;
        end
      end
      default: begin
        w_out_ld  = 1'b0;
        w_out_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa  <= '0;
      r_opb  <= '0;
      r_cmd  <= '0;
      r_mode <= 1'b0;
      r_cin  <= 1'b0;
    end else if (alu_bus.ce) begin
      if (w_lat_a) r_opa <= alu_bus.opa;
      if (w_lat_b) r_opb <= alu_bus.opb;
      if (w_lat_a || w_lat_b) begin
        r_cmd  <= alu_bus.cmd;
        r_mode <= alu_bus.mode;
        r_cin  <= alu_bus.cin;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else if (alu_bus.ce && w_out_ld) begin
      r_out <= w_out_nxt;
    end
  end

`ifdef ALU_OUT_PIPE_EN
  result_t r_out_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_p <= '0;
    end else if (alu_bus.ce) begin
      r_out_p <= r_out;
    end
  end

  assign w_out_q = r_out_p;
`else
  assign w_out_q = r_out;
`endif

  assign alu_bus.res   = w_out_q.res;
  assign alu_bus.cout  = w_out_q.cout;
  assign alu_bus.oflow = w_out_q.oflow;
  assign alu_bus.g     = w_out_q.g;
  assign alu_bus.l     = w_out_q.l;
  assign alu_bus.e     = w_out_q.e;
  assign alu_bus.err   = w_out_q.err;
endmodule

// File: tb/tb_alu_rtl.sv
// Self-checking bench for alu_rtl: directed vector table, split/timeout/hold/reset sequences, random vs reference model.
module tb_alu_rtl;
  localparam int W  = 8;
  localparam int TO = 16;
  localparam int M  = 512;
`ifdef ALU_OUT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_if #(.WIDTH(W), .CMD_WIDTH(4)) bus ();

  alu_rtl #(.WIDTH(W), .CMD_WIDTH(4), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .alu_bus (bus)
  );

  // fl = {cout, oflow, g, l, e, err}
  typedef struct {
    int       res;
    bit [5:0] fl;
  } exp_t;

  typedef struct {
    bit       mode;
    int       cmd;
    bit [1:0] iv;
    int       a;
    int       b;
    bit       cin;
    int       res;
    bit [5:0] fl;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Reference model state: at most one captured operand awaiting its partner.
  bit   pend_a, pend_b;
  int   pa, pb, pcmd, waited;
  bit   pmode, pcin;
  exp_t s1, sp;

  function automatic exp_t calc(bit mode, int cmd, int a, int b, bit cin);
    exp_t r;
    r.res = 0;
    r.fl  = '0;
    if (mode) begin
      case (cmd)
        0: begin r.res = a + b;       r.fl[5] = (r.res >= 256); end
        1: begin r.res = (a - b + M) % M;       r.fl[4] = (a < b); end
        2: begin r.res = a + b + cin; r.fl[5] = (r.res >= 256); end
        3: begin r.res = (a - b - cin + M) % M; r.fl[4] = (a < b + cin); end
        4: r.res = (a + 1) % M;
        5: r.res = (a - 1 + M) % M;
        6: r.res = (b + 1) % M;
        7: r.res = (b - 1 + M) % M;
        8: begin r.fl[3] = (a > b); r.fl[2] = (a < b); r.fl[1] = (a == b); end
        default: r.fl[0] = 1'b1;
      endcase
    end else begin
      case (cmd)
        0:  r.res = a & b;
        1:  r.res = ~(a & b) & 255;
        2:  r.res = a | b;
        3:  r.res = ~(a | b) & 255;
        4:  r.res = a ^ b;
        5:  r.res = ~(a ^ b) & 255;
        6:  r.res = ~a & 255;
        7:  r.res = ~b & 255;
        8:  r.res = a / 2;
        9:  r.res = (a * 2) % 256;
        10: r.res = b / 2;
        11: r.res = (b * 2) % 256;
        12: if (b >= W) r.fl[0] = 1'b1; else r.res = ((a << b) | (a >> (W - b))) & 255;
        13: if (b >= W) r.fl[0] = 1'b1; else r.res = ((a >> b) | (a << (W - b))) & 255;
        default: r.fl[0] = 1'b1;
      endcase
    end
    return r;
  endfunction

  function automatic bit [1:0] need(bit mode, int cmd);
    if (mode) begin
      if (cmd == 4 || cmd == 5) return 2'b01;
      if (cmd == 6 || cmd == 7) return 2'b10;
    end else begin
      if (cmd == 6 || cmd == 8 || cmd == 9) return 2'b01;
      if (cmd == 7 || cmd == 10 || cmd == 11) return 2'b10;
    end
    return 2'b11;
  endfunction

  function automatic bit legal(bit mode, int cmd);
    return mode ? (cmd <= 8) : (cmd <= 13);
  endfunction

  function automatic exp_t err_res();
    exp_t r;
    r.res = 0;
    r.fl  = 6'b000001;
    return r;
  endfunction

  function automatic exp_t vis();
    return (LAT == 2) ? sp : s1;
  endfunction

  task automatic model_reset();
    pend_a = 0; pend_b = 0; pa = 0; pb = 0; pcmd = 0; pmode = 0; pcin = 0; waited = 0;
    s1 = '{0, 6'b0};
    sp = '{0, 6'b0};
  endtask

  task automatic model_step(bit ce, bit mode, int cmd, bit [1:0] iv, int a, int b, bit cin);
    exp_t     nx;
    bit       upd;
    bit [1:0] nd;
    upd = 0;
    nx  = '{0, 6'b0};
    if (!ce) return;
    if (pend_a || pend_b) begin
      waited++;
      if (pend_a && iv[1]) begin
        nx = calc(pmode, pcmd, iv[0] ? a : pa, b, pcin); upd = 1; pend_a = 0;
      end else if (pend_b && iv[0]) begin
        nx = calc(pmode, pcmd, a, iv[1] ? b : pb, pcin); upd = 1; pend_b = 0;
      end else if (waited == TO) begin
        nx = err_res(); upd = 1; pend_a = 0; pend_b = 0;
      end
    end else if (iv != 2'b00) begin
      nd = need(mode, cmd);
      if (!legal(mode, cmd)) begin
        nx = err_res(); upd = 1;
      end else if ((iv & nd) == nd) begin
        nx = calc(mode, cmd, a, b, cin); upd = 1;
      end else if (nd == 2'b11) begin
        if (iv == 2'b01) begin pend_a = 1; pa = a; end
        else             begin pend_b = 1; pb = b; end
        pcmd = cmd; pmode = mode; pcin = cin; waited = 0;
      end else begin
        nx = err_res(); upd = 1;
      end
    end
    sp = s1;
    if (upd) s1 = nx;
  endtask

  task automatic chk(string nm, int got, int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  task automatic chk_out(string nm, exp_t x);
    chk({nm, " res"}, int'(bus.res), x.res);
    chk({nm, " flags"}, int'({bus.cout, bus.oflow, bus.g, bus.l, bus.e, bus.err}), int'(x.fl));
  endtask

  // Present one cycle of stimulus, advance the model, sample 1 ns after the edge.
  task automatic drive(bit ce, bit mode, int cmd, bit [1:0] iv, int a, int b, bit cin);
    bus.ce = ce; bus.mode = mode; bus.cmd = 4'(cmd); bus.inp_valid = iv;
    bus.opa = 8'(a); bus.opb = 8'(b); bus.cin = cin;
    model_step(ce, mode, cmd, iv, a, b, cin);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1, 0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic do_reset(string nm);
    bus.ce = 0; bus.inp_valid = 2'b00;
    rst = 1'b1;
    model_reset();
    #2;
    chk_out(nm, '{0, 6'b0});
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t vt[22];

  initial begin
    vt[0]  = '{1, 0,  2'b11, 'hFF, 'h01, 0, 'h100, 6'b100000};
    vt[1]  = '{1, 1,  2'b11, 'h10, 'h20, 0, 'h1F0, 6'b010000};
    vt[2]  = '{1, 2,  2'b11, 'hFF, 'hFF, 1, 'h1FF, 6'b100000};
    vt[3]  = '{1, 3,  2'b11, 'h05, 'h05, 1, 'h1FF, 6'b010000};
    vt[4]  = '{1, 5,  2'b01, 'h00, 'h33, 0, 'h1FF, 6'b000000};
    vt[5]  = '{1, 6,  2'b10, 'h12, 'hFF, 0, 'h100, 6'b000000};
    vt[6]  = '{1, 8,  2'b11, 'h05, 'h05, 0, 'h000, 6'b000010};
    vt[7]  = '{1, 8,  2'b11, 'h06, 'h05, 0, 'h000, 6'b001000};
    vt[8]  = '{1, 8,  2'b11, 'h04, 'h05, 0, 'h000, 6'b000100};
    vt[9]  = '{0, 0,  2'b11, 'hF0, 'h3C, 0, 'h030, 6'b000000};
    vt[10] = '{0, 3,  2'b11, 'hF0, 'h0F, 0, 'h000, 6'b000000};
    vt[11] = '{0, 5,  2'b11, 'hAA, 'h0F, 0, 'h05A, 6'b000000};
    vt[12] = '{0, 12, 2'b11, 'h81, 'h01, 0, 'h003, 6'b000000};
    vt[13] = '{0, 12, 2'b11, 'h81, 'h11, 0, 'h000, 6'b000001};
    vt[14] = '{0, 13, 2'b11, 'h81, 'h01, 0, 'h0C0, 6'b000000};
    vt[15] = '{0, 9,  2'b01, 'h81, 'h00, 0, 'h002, 6'b000000};
    vt[16] = '{0, 10, 2'b10, 'h00, 'h81, 0, 'h040, 6'b000000};
    vt[17] = '{0, 6,  2'b01, 'h0F, 'h00, 0, 'h0F0, 6'b000000};
    vt[18] = '{1, 9,  2'b11, 'h01, 'h01, 0, 'h000, 6'b000001};
    vt[19] = '{1, 4,  2'b10, 'h01, 'h01, 0, 'h000, 6'b000001};
    vt[20] = '{0, 14, 2'b11, 'h01, 'h01, 0, 'h000, 6'b000001};
    vt[21] = '{1, 7,  2'b10, 'h00, 'h00, 0, 'h1FF, 6'b000000};

    bus.ce = 0; bus.mode = 0; bus.cmd = '0; bus.inp_valid = 2'b00;
    bus.opa = '0; bus.opb = '0; bus.cin = 0;
    rst = 1'b1;
    model_reset();
    #2;
    chk_out("reset", '{0, 6'b0});
    #10;
    rst = 1'b0;

    // Directed single-transaction vectors.
    for (int i = 0; i < 22; i++) begin
      drive(1, vt[i].mode, vt[i].cmd, vt[i].iv, vt[i].a, vt[i].b, vt[i].cin);
      idle(LAT - 1);
      chk_out($sformatf("vec%0d", i), '{vt[i].res, vt[i].fl});
    end

    // Split SUB: opa first, gaps, then opb with a different (ignored) command.
    drive(1, 1, 1, 2'b01, 'h10, 'h00, 0);
    chk_out("split_hold", '{'h1FF, 6'b0});
    idle(3);
    drive(1, 0, 5, 2'b10, 'h00, 'h20, 0);
    idle(LAT - 1);
    chk_out("split_sub", '{'h1F0, 6'b010000});

    // Timeout after 16 empty wait cycles.
    drive(1, 1, 0, 2'b01, 'h03, 'h00, 0);
    idle(15);
    chk_out("timeout_pre", '{'h1F0, 6'b010000});
    idle(1);
    idle(LAT - 1);
    chk_out("timeout", '{0, 6'b000001});
    drive(1, 1, 0, 2'b11, 'h01, 'h02, 0);
    idle(LAT - 1);
    chk_out("after_timeout", '{'h003, 6'b0});

    // ce=0 in WAIT_B freezes the counter and outputs.
    drive(1, 1, 0, 2'b01, 'h40, 'h00, 0);
    idle(2);
    repeat (5) drive(0, 1, 0, 2'b10, 'h00, 'h01, 0);
    chk_out("ce_hold", '{'h003, 6'b0});
    idle(13);
    chk_out("ce_no_timeout", '{'h003, 6'b0});

    // Reset mid-wait drops the captured opa; a lone opb then waits in WAIT_A.
    do_reset("reset_mid_wait");
    drive(1, 1, 0, 2'b10, 'h00, 'h07, 0);
    idle(LAT - 1);
    chk_out("opb_alone", '{0, 6'b0});
    drive(1, 0, 0, 2'b01, 'h05, 'h00, 0);
    idle(LAT - 1);
    chk_out("wait_a_done", '{'h00C, 6'b0});

    // Randomised traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      bit       ce, mode, cin;
      int       cmd, a, b;
      bit [1:0] iv;
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rand_reset");
      end else begin
        ce   = ($urandom_range(0, 9) != 0);
        mode = 1'($urandom_range(0, 1));
        cmd  = int'($urandom_range(0, 15));
        iv   = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
        a    = int'($urandom_range(0, 255));
        b    = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255));
        cin  = 1'($urandom_range(0, 1));
        drive(ce, mode, cmd, iv, a, b, cin);
        chk_out("rand", vis());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
